alu_multicycle: RTL and testbench

//   Parametrised, registered ALU with a start/done handshake. Executes single-cycle

---
 rtl/alu_multicycle.sv | 191 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU with start/done handshake: single-cycle logic/shift/compare ops,
// WIDTH-cycle shift-add multiply and restoring unsigned divide/remainder.
module alu_multicycle #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         alu_operation,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpSll  = 4'd4;
  localparam logic [3:0] OpSrl  = 4'd5;
  localparam logic [3:0] OpSra  = 4'd6;
  localparam logic [3:0] OpSlt  = 4'd7;
  localparam logic [3:0] OpSltu = 4'd8;
  localparam logic [3:0] OpMul  = 4'd9;
  localparam logic [3:0] OpDivu = 4'd10;
  localparam logic [3:0] OpRemu = 4'd11;

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // a: mul accumulator / div remainder; b: multiplicand / divisor;
  // c: multiplier / dividend shifting into quotient.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               rem_sel_q, rem_sel_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   res_nx;
  logic               ovf_nx;
  logic               fin;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_nx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    rem_sel_d  = rem_sel_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    res_nx     = '0;
    ovf_nx     = 1'b0;
    fin        = 1'b0;
    sum        = operand1 + operand2;
    diff       = operand1 - operand2;
    rem_sh     = {a_q, c_q[WIDTH-1]};
    rem_ge     = (rem_sh >= {1'b0, b_q});
    rem_nx     = rem_sh[WIDTH-1:0] - b_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          fin = 1'b1;
          case (alu_operation)
            OpAdd: begin
              res_nx = sum;
              ovf_nx = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                       (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OpSub: begin
              res_nx = diff;
              ovf_nx = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                       (diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            OpAnd:  res_nx = operand1 & operand2;
            OpOr:   res_nx = operand1 | operand2;
            OpSll:  res_nx = operand2 << shamt;
            OpSrl:  res_nx = operand2 >> shamt;
            OpSra:  res_nx = $unsigned($signed(operand2) >>> shamt);
            OpSlt:  res_nx = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OpSltu: res_nx = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            OpMul: begin
              fin     = 1'b0;
              a_d     = '0;
              b_d     = operand1;
              c_d     = operand2;
              cnt_d   = SHAMT_W'(WIDTH - 1);
              state_d = StMul;
            end
            OpDivu, OpRemu: begin
              if (operand2 == '0) begin
                // Divide by zero finishes immediately without iterating.
                res_nx = (alu_operation == OpRemu) ? operand1 : '1;
              end else begin
                fin       = 1'b0;
                a_d       = '0;
                b_d       = operand2;
                c_d       = operand1;
                rem_sel_d = (alu_operation == OpRemu);
                cnt_d     = SHAMT_W'(WIDTH - 1);
                state_d   = StDiv;
              end
            end
            default: res_nx = '0;
          endcase
        end
      end
      StMul: begin
        a_d   = a_q + (c_q[0] ? b_q : '0);
        b_d   = b_q << 1;
        c_d   = c_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          fin     = 1'b1;
          res_nx  = a_d;
          state_d = StIdle;
        end
      end
      StDiv: begin
        a_d   = rem_ge ? rem_nx : rem_sh[WIDTH-1:0];
        c_d   = {c_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          fin     = 1'b1;
          res_nx  = rem_sel_q ? a_d : c_d;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fin) begin
      result_d   = res_nx;
      zero_d     = (res_nx == '0);
      overflow_d = ovf_nx;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      rem_sel_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      rem_sel_q  <= rem_sel_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32): vector table for single-cycle ops
// plus hand-written multiply/divide, mid-run start, back-to-back and reset sequences.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_operation = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        zero, overflow, busy, done;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .alu_operation (alu_operation),
    .operand1      (operand1),
    .operand2      (operand2),
    .shamt         (shamt),
    .result        (result),
    .zero          (zero),
    .overflow      (overflow),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    alu_operation = op;
    operand1      = a;
    operand2      = b;
    shamt         = sh;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  // Iterative op: counts busy cycles, optionally pokes an add start mid-run.
  task automatic run_multi(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input bit poke);
    int n;
    logic [31:0] prev;
    prev = result;
    issue(op, a, b, 5'd0);
    operand1 = 32'hDEAD_BEEF;
    operand2 = 32'h1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 10 && poke) begin
        alu_operation = 4'd0;
        operand1      = 32'd1;
        operand2      = 32'd2;
        start         = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (n == 20) begin
        chk({name, " result held mid-run"}, result, prev);
        chk({name, " no done mid-run"}, {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, " busy cycles"}, n, 32);
    chk({name, " done"}, {31'd0, done}, 32'd1);
    chk({name, " result"}, result, exp);
    chk({name, " overflow"}, {31'd0, overflow}, 32'd0);
    chk({name, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'd3,         32'd5,         5'd0, 32'd8,         1'b0, 1'b0};
    vecs[1]  = '{4'd1,  32'd25,        32'd25,        5'd0, 32'd0,         1'b1, 1'b0};
    vecs[2]  = '{4'd0,  32'h7FFFFFFF,  32'd1,         5'd0, 32'h80000000,  1'b0, 1'b1};
    vecs[3]  = '{4'd1,  32'h80000000,  32'd1,         5'd0, 32'h7FFFFFFF,  1'b0, 1'b1};
    vecs[4]  = '{4'd2,  32'hF0F0F0F0,  32'hFF00FF00,  5'd0, 32'hF000F000,  1'b0, 1'b0};
    vecs[5]  = '{4'd3,  32'h0F0F0000,  32'h000000F0,  5'd0, 32'h0F0F00F0,  1'b0, 1'b0};
    vecs[6]  = '{4'd4,  32'd0,         32'hFFFFFFF8,  5'd2, 32'hFFFFFFE0,  1'b0, 1'b0};
    vecs[7]  = '{4'd5,  32'd0,         32'hFFFFFFF8,  5'd2, 32'h3FFFFFFE,  1'b0, 1'b0};
    vecs[8]  = '{4'd6,  32'd0,         32'hFFFFFFF8,  5'd2, 32'hFFFFFFFE,  1'b0, 1'b0};
    vecs[9]  = '{4'd6,  32'd0,         32'hFFFFFFF8,  5'd0, 32'hFFFFFFF8,  1'b0, 1'b0};
    vecs[10] = '{4'd7,  32'hFFFFFFFD,  32'd5,         5'd0, 32'd1,         1'b0, 1'b0};
    vecs[11] = '{4'd8,  32'hFFFFFFFD,  32'd5,         5'd0, 32'd0,         1'b1, 1'b0};
    vecs[12] = '{4'd12, 32'd7,         32'd9,         5'd3, 32'd0,         1'b1, 1'b0};
    vecs[13] = '{4'd1,  32'd0,         32'd1,         5'd0, 32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[14] = '{4'd10, 32'd100,       32'd0,         5'd0, 32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[15] = '{4'd11, 32'd100,       32'd0,         5'd0, 32'd100,       1'b0, 1'b0};

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset result", result, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd1);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Single-cycle ops: done one cycle after accept, single pulse, busy never set
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      operand1 = 32'h5555_AAAA;
      operand2 = 32'h1234_5678;
      chk($sformatf("vec%0d done", i), {31'd0, done}, 32'd1);
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].o});
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d held", i), result, vecs[i].res);
    end

    // Overflow left set by a previous add must clear on a mul
    issue(4'd0, 32'h7FFFFFFF, 32'd1, 5'd0);
    run_multi("mul -3*5", 4'd9, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b1);
    @(negedge clk);
    chk("mul start ignored", result, 32'hFFFFFFF1);
    chk("mul no extra done", {31'd0, done}, 32'd0);
    run_multi("mul big", 4'd9, 32'h12345678, 32'h10, 32'h23456780, 1'b0);
    run_multi("mul wrap zero", 4'd9, 32'h00010000, 32'h00010000, 32'd0, 1'b0);
    run_multi("divu 100/7", 4'd10, 32'd100, 32'd7, 32'd14, 1'b0);

    // Back-to-back: start held in the done cycle is accepted
    alu_operation = 4'd0;
    operand1      = 32'd2;
    operand2      = 32'd2;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b done", {31'd0, done}, 32'd1);
    chk("b2b result", result, 32'd4);

    run_multi("remu 100/7", 4'd11, 32'd100, 32'd7, 32'd2, 1'b0);
    run_multi("divu max/3", 4'd10, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0);

    // Reset 10 cycles into a mul
    issue(4'd9, 32'd1234, 32'd5678, 5'd0);
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset result", result, 32'd0);
    chk("async reset zero", {31'd0, zero}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) begin
        chk("post-reset idle", {30'd0, busy, done}, 32'd0);
        break;
      end
    end
    issue(4'd0, 32'd1, 32'd1, 5'd0);
    chk("post-reset add done", {31'd0, done}, 32'd1);
    chk("post-reset add", result, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
